kbd_seg_io: RTL and testbench

// - Memory-mapped I/O slave on the mammal CPU bus (12-bit address, 16-bit data).
// - Contains a PS/2 keyboard scancode receiver and a 4-digit multiplexed hex seven-segment driver.
// - The top level ORs rd_data into the CPU data_in mux when hit=1; RAM and VGA decode stay outside.

---
 rtl/kbd_seg_pkg.sv | 42 ++++
 rtl/kbd_seg_io_ps2_rx.sv | 112 +++++++++++
 rtl/kbd_seg_io.sv | 83 ++++++++
 tb/tb_kbd_seg_io.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/kbd_seg_pkg.sv
// Shared definitions for the keyboard / seven-segment I/O slave:
// bus addresses, receiver states and the hex segment font.
package kbd_seg_pkg;

    localparam logic [11:0] KBD_DATA_ADDR = 12'h900;
    localparam logic [11:0] KBD_STAT_ADDR = 12'h901;
    localparam logic [11:0] SEG_ADDR      = 12'hb00;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Font table is written as abcdefg and returned as {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] abc;
        logic [6:0] gfe;
        case (nib)
            4'h0: abc = 7'b1111110;
            4'h1: abc = 7'b0110000;
            4'h2: abc = 7'b1101101;
            4'h3: abc = 7'b1111001;
            4'h4: abc = 7'b0110011;
            4'h5: abc = 7'b1011011;
            4'h6: abc = 7'b1011111;
            4'h7: abc = 7'b1110000;
            4'h8: abc = 7'b1111111;
            4'h9: abc = 7'b1111011;
            4'ha: abc = 7'b1110111;
            4'hb: abc = 7'b0011111;
            4'hc: abc = 7'b1001110;
            4'hd: abc = 7'b0111101;
            4'he: abc = 7'b1001111;
            default: abc = 7'b1000111;
        endcase
        for (int i = 0; i < 7; i++) gfe[i] = abc[6-i];
        return gfe;
    endfunction

endpackage

// File: rtl/kbd_seg_io_ps2_rx.sv
// PS/2 scancode receiver: input synchronisers, ps2c glitch filter,
// frame FSM with odd-parity / stop check and idle timeout.
import kbd_seg_pkg::*;

module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int PS2_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] code,
    output logic       done
);

    localparam int TW = $clog2(PS2_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(PS2_TIMEOUT - 1);

    logic [1:0]            c_sync_q, c_sync_d, d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  filt_q, filt_d, fall, din;
    rx_state_t             state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            shift_q, shift_d, code_q, code_d;
    logic                  par_q, par_d, done_q, done_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            hist_q   <= '1;
            filt_q   <= 1'b1;
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            code_q   <= '0;
            done_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            hist_q   <= hist_d;
            filt_q   <= filt_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            code_q   <= code_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
        hist_d   = {hist_q[FILTER_LEN-2:0], c_sync_q[1]};
        // Filtered level only moves once the whole history window agrees.
        if (&hist_q)       filt_d = 1'b1;
        else if (~|hist_q) filt_d = 1'b0;
        else               filt_d = filt_q;
        fall = filt_q & ~filt_d;
        din  = d_sync_q[1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        code_d  = code_q;
        done_d  = 1'b0;
        tmo_d   = '0;
        if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!din) begin
                        state_d = RX_DATA;
                        cnt_d   = '0;
                    end
                end
                RX_DATA: begin
                    shift_d = {din, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = din;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if (din && (^{shift_q, par_q})) begin
                        code_d = shift_q;
                        done_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE) begin
            if (tmo_q == TMO_LAST) state_d = RX_IDLE;
            else                   tmo_d   = tmo_q + 1'b1;
        end
    end

    assign code = code_q;
    assign done = done_q;

endmodule

// File: rtl/kbd_seg_io.sv
// Memory-mapped keyboard + 4-digit seven-segment slave for the CPU bus.
// Reads are purely combinational; only full, seg_reg and the scan counter are state.
import kbd_seg_pkg::*;

module kbd_seg_io #(
    parameter int          REFRESH_BITS = 16,
    parameter int          FILTER_LEN   = 8,
    parameter int          PS2_TIMEOUT  = 50000,
    parameter logic [15:0] SEG_RESET    = 16'h1515
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2c,
    input  logic        ps2d,
    input  logic [11:0] address,
    input  logic [15:0] data_out,
    input  logic        memwt,
    input  logic        intack,
    output logic [15:0] rd_data,
    output logic        hit,
    output logic [6:0]  display,
    output logic [3:0]  grounds
);

    logic [7:0]              rx_code;
    logic                    rx_done;
    logic                    full_q, full_d;
    logic [15:0]             seg_q, seg_d;
    logic [REFRESH_BITS-1:0] scan_q, scan_d;
    logic                    kbd_sel, seg_sel, ack;
    logic [1:0]              digit;
    logic [3:0]              nib;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .PS2_TIMEOUT(PS2_TIMEOUT)
    ) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .ps2c (ps2c),
        .ps2d (ps2d),
        .code (rx_code),
        .done (rx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            seg_q  <= SEG_RESET;
            scan_q <= '0;
        end else begin
            full_q <= full_d;
            seg_q  <= seg_d;
            scan_q <= scan_d;
        end
    end

    always_comb begin
        kbd_sel = (address == KBD_DATA_ADDR) || (address == KBD_STAT_ADDR);
        seg_sel = (address == SEG_ADDR);
        hit     = !intack && (kbd_sel || seg_sel);
        ack     = !intack && (address == KBD_DATA_ADDR);
        rd_data = 16'h0;
        if (!intack) begin
            if (kbd_sel)      rd_data = {full_q, 7'b0, rx_code};
            else if (seg_sel) rd_data = seg_q;
        end
        // A frame landing in an ack cycle must not be lost.
        if (rx_done)  full_d = 1'b1;
        else if (ack) full_d = 1'b0;
        else          full_d = full_q;
        seg_d  = (memwt && seg_sel && !intack) ? data_out : seg_q;
        scan_d = scan_q + 1'b1;
    end

    always_comb begin
        digit   = scan_q[REFRESH_BITS-1 -: 2];
        nib     = seg_q[{digit, 2'b00} +: 4];
        display = seg_font(nib);
        grounds = ~(4'b0001 << digit);
    end

endmodule

// File: tb/tb_kbd_seg_io.sv
// Directed bench for kbd_seg_io: expected values are queued as stimulus is
// applied and popped when the matching DUT output is sampled.
module tb_kbd_seg_io;

    localparam int HALF = 400;  // PS/2 half bit period in ns (40 clk)
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ps2c, ps2d;
    logic [11:0] address;
    logic [15:0] data_out;
    logic        memwt, intack;
    logic [15:0] rd_data;
    logic        hit;
    logic [6:0]  display;
    logic [3:0]  grounds;

    int          vecs = 0;
    int          errs = 0;
    string       tag_q[$];
    logic [15:0] exp_q[$];
    logic        seen;
    logic [15:0] v;
    logic [3:0]  gexp[4];
    logic [6:0]  dexp[4];

    kbd_seg_io #(
        .REFRESH_BITS(4),
        .FILTER_LEN  (8),
        .PS2_TIMEOUT (TMO),
        .SEG_RESET   (16'h1515)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2c    (ps2c),
        .ps2d    (ps2d),
        .address (address),
        .data_out(data_out),
        .memwt   (memwt),
        .intack  (intack),
        .rd_data (rd_data),
        .hit     (hit),
        .display (display),
        .grounds (grounds)
    );

    always #5 clk = ~clk;

    task automatic push(input string t, input logic [15:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        vecs++;
        assert (obs === e) else begin
            errs++;
            $error("FAIL %s: got %h want %h", t, obs, e);
        end
    endtask

    task automatic rd_chk(input string t, input logic [11:0] a, input logic [15:0] e);
        logic [15:0] r;
        push(t, e);
        @(negedge clk);
        address = a;
        #1 r = rd_data;
        address = 12'h000;
        chk(r);
    endtask

    task automatic ack_cycle();
        @(negedge clk);
        address = 12'h900;
        @(negedge clk);
        address = 12'h000;
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        #(HALF);
        ps2c = 1'b0;
        #(HALF);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2d = 1'b1;
        #(HALF);
    endtask

    initial begin
        gexp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        dexp = '{7'b1110001, 7'b1110111, 7'b1011011, 7'b0000110};
        rst_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1;
        address = 12'h000; data_out = 16'h0; memwt = 1'b0; intack = 1'b0;
        repeat (3) @(negedge clk);
        push("rst_grounds", 16'h000e);
        chk({12'b0, grounds});
        rst_n = 1'b1;

        rd_chk("rst_seg", 12'hb00, 16'h1515);
        rd_chk("rst_stat", 12'h901, 16'h0000);

        send_frame(8'h1C, 1'b0, 1'b0);
        rd_chk("frame_stat1", 12'h901, 16'h801C);
        rd_chk("frame_stat2", 12'h901, 16'h801C);
        push("frame_data", 16'h801C);
        @(negedge clk);
        address = 12'h900;
        #1 v = rd_data;
        chk(v);
        @(negedge clk);
        address = 12'h000;
        rd_chk("after_ack", 12'h901, 16'h001C);

        send_frame(8'h1C, 1'b1, 1'b0);
        rd_chk("bad_parity", 12'h901, 16'h001C);
        send_frame(8'h1C, 1'b0, 1'b1);
        rd_chk("bad_stop", 12'h901, 16'h001C);

        // Short ps2c glitch with data low must not start a frame.
        ps2d = 1'b0;
        ps2c = 1'b0;
        #20 ps2c = 1'b1;
        ps2d = 1'b1;
        #(HALF);
        send_frame(8'h5A, 1'b0, 1'b0);
        rd_chk("glitch", 12'h901, 16'h805A);
        ack_cycle();

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b0);
        ps2d = 1'b1;
        repeat (TMO + 100) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b0);
        rd_chk("timeout", 12'h901, 16'h8029);
        ack_cycle();

        @(negedge clk);
        address = 12'hb00; data_out = 16'h12AF; memwt = 1'b1;
        @(negedge clk);
        memwt = 1'b0; address = 12'h000;
        rd_chk("seg_write", 12'hb00, 16'h12AF);
        for (int k = 0; k < 64 && grounds !== 4'b1110; k++) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            push("scan_grounds", {12'b0, gexp[d]});
            chk({12'b0, grounds});
            push("scan_display", {9'b0, dexp[d]});
            chk({9'b0, display});
            repeat (4) @(negedge clk);
        end

        push("intack_hit", 16'h0);
        push("intack_rd", 16'h0);
        @(negedge clk);
        address = 12'hb00; intack = 1'b1; memwt = 1'b1; data_out = 16'hDEAD;
        #1 chk({15'b0, hit});
        chk(rd_data);
        @(negedge clk);
        memwt = 1'b0; intack = 1'b0; address = 12'h000;
        rd_chk("intack_write", 12'hb00, 16'h12AF);

        push("other_hit", 16'h0);
        push("other_rd", 16'h0);
        @(negedge clk);
        address = 12'h123;
        #1 chk({15'b0, hit});
        chk(rd_data);
        address = 12'h000;

        // Frame completes while the data address is held: full must still rise.
        seen = 1'b0;
        @(negedge clk);
        address = 12'h900;
        fork
            send_frame(8'h1C, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 3000 && !seen; k++) begin
                    @(negedge clk);
                    if (rd_data[15]) begin
                        seen = 1'b1;
                        address = 12'h901;
                    end
                end
            end
        join
        address = 12'h000;
        push("ack_race_seen", 16'h1);
        chk({15'b0, seen});
        rd_chk("ack_race_word", 12'h901, 16'h801C);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
